// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, frame-based debounce, one-cycle press strobe with key code.
// Strobe lands 1 cycle after the closing frame end; no backpressure, strobes are never held off.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic [3:0] col_drive,
  output logic       strobe,
  output logic [7:0] cur_key,
  output logic       key_held,
  output logic [1:0] scan_state
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [3:0]    row_m, row_s;
  logic [DW-1:0] div_cnt;
  logic          sample, frame_end;
  logic [2:0]    hits;
  logic [1:0]    seen, seen_nx;
  logic [7:0]    seen_key, seen_key_nx;

  state_t        state, state_nx;
  logic [7:0]    cand, cand_nx, cur_key_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc, rcnt, rcnt_nx, rcnt_inc;
  logic          strobe_nx, key_held_nx, fire;
  logic          res_none, res_single;

  assign sample     = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end  = sample && (col_drive == 4'b0001);
  assign hits       = 3'($countones(row_s));
  assign scan_state = state;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_m     <= '0;
      row_s     <= '0;
      div_cnt   <= '0;
      col_drive <= 4'b1000;
      seen      <= '0;
      seen_key  <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      if (sample) begin
        div_cnt   <= '0;
        col_drive <= {col_drive[0], col_drive[3:1]};
        seen      <= frame_end ? 2'd0 : seen_nx;
        seen_key  <= seen_key_nx;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // seen counts distinct (row, col) pairs in the frame, saturating at 2 (= MULTI)
  always_comb begin
    seen_nx     = seen;
    seen_key_nx = seen_key;
    if (hits == 3'd1 && seen == 2'd0) begin
      seen_nx     = 2'd1;
      seen_key_nx = {row_s, col_drive};
    end else if (hits != 3'd0) begin
      seen_nx = 2'd2;
    end
  end

  assign res_none   = (seen_nx == 2'd0);
  assign res_single = (seen_nx == 2'd1);
  assign cnt_inc    = (cnt == CW'(DEBOUNCE)) ? cnt : cnt + 1'b1;
  assign rcnt_inc   = (rcnt == CW'(DEBOUNCE)) ? rcnt : rcnt + 1'b1;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= S_IDLE;
      cand     <= '0;
      cnt      <= '0;
      rcnt     <= '0;
      cur_key  <= '0;
      strobe   <= 1'b0;
      key_held <= 1'b0;
    end else begin
      state    <= state_nx;
      cand     <= cand_nx;
      cnt      <= cnt_nx;
      rcnt     <= rcnt_nx;
      cur_key  <= cur_key_nx;
      strobe   <= strobe_nx;
      key_held <= key_held_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cand_nx     = cand;
    cnt_nx      = cnt;
    rcnt_nx     = rcnt;
    cur_key_nx  = cur_key;
    strobe_nx   = 1'b0;
    key_held_nx = key_held;
    fire        = 1'b0;
    if (frame_end) begin
      case (state)
        S_IDLE: begin
          if (res_single) begin
            cand_nx = seen_key_nx;
            cnt_nx  = CW'(1);
            if (DEBOUNCE == 1) fire = 1'b1;
            else state_nx = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (res_single && seen_key_nx == cand) begin
            cnt_nx = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE)) fire = 1'b1;
          end else if (res_single) begin
            cand_nx = seen_key_nx;
            cnt_nx  = CW'(1);
          end else begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end
        end
        S_HELD: begin
          if (res_none) begin
            if (DEBOUNCE == 1) begin
              key_held_nx = 1'b0;
              state_nx    = S_IDLE;
            end else begin
              rcnt_nx  = CW'(1);
              state_nx = S_RELEASE;
            end
          end
        end
        default: begin
          if (res_none) begin
            rcnt_nx = rcnt_inc;
            if (rcnt_inc >= CW'(DEBOUNCE)) begin
              key_held_nx = 1'b0;
              state_nx    = S_IDLE;
              rcnt_nx     = '0;
            end
          end else begin
            state_nx = S_HELD;
            rcnt_nx  = '0;
          end
        end
      endcase
    end
    if (fire) begin
      cur_key_nx  = cand_nx;
      strobe_nx   = 1'b1;
      key_held_nx = 1'b1;
      cnt_nx      = '0;
      state_nx    = S_HELD;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix and a key-code scoreboard.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       nRst;
  logic [3:0] row;
  logic [3:0] col_drive;
  logic       strobe;
  logic [7:0] cur_key;
  logic       key_held;
  logic [1:0] scan_state;

  logic [3:0] keys [4];
  logic [7:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;
  int         nstrobe = 0;
  logic       prev_strobe = 1'b0;
  int         base;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .row        (row),
    .col_drive  (col_drive),
    .strobe     (strobe),
    .cur_key    (cur_key),
    .key_held   (key_held),
    .scan_state (scan_state)
  );

  always #5 clk = ~clk;

  // pressed keys in the driven column short their rows onto the row lines
  always_comb begin
    row = 4'b0000;
    for (int c = 0; c < 4; c++)
      if (col_drive[c]) row = row | keys[c];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    @(negedge clk);
    if (strobe === 1'b1) begin
      nstrobe++;
      check("strobe_width", 32'(prev_strobe), 32'd0);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe_key", 32'(cur_key), 32'(e));
        check("strobe_held", 32'(key_held), 32'd1);
      end
    end
    prev_strobe = strobe;
  endtask

  task automatic frames(input int n);
    repeat (16 * n) tick();
  endtask

  task automatic align();
    int n;
    logic [3:0] last;
    n = 0;
    last = col_drive;
    tick();
    while (!(col_drive == 4'b1000 && last == 4'b0001) && n < 100) begin
      last = col_drive;
      tick();
      n++;
    end
    check("align_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic press(input logic [7:0] k);
    for (int c = 0; c < 4; c++)
      if (k[c]) keys[c] = keys[c] | k[7:4];
  endtask

  task automatic clear_keys();
    for (int c = 0; c < 4; c++) keys[c] = 4'b0000;
  endtask

  initial begin
    clear_keys();
    nRst = 1'b0;
    // T1: reset values, then R2 C0 held from reset release
    press(8'h28);
    @(negedge clk);
    @(negedge clk);
    check("rst_col", 32'(col_drive), 32'h8);
    check("rst_strobe", 32'(strobe), 32'd0);
    check("rst_key", 32'(cur_key), 32'h00);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_state", 32'(scan_state), 32'd0);
    exp_q.push_back(8'h28);
    nRst = 1'b1;
    base = nstrobe;
    repeat (47) tick();
    check("t1_no_early", 32'(nstrobe), 32'(base));
    tick();
    check("t1_strobe_48", 32'(nstrobe), 32'(base + 1));
    check("t1_state_held", 32'(scan_state), 32'd2);
    clear_keys();
    repeat (47) tick();
    check("t1_held_before_rel", 32'(key_held), 32'd1);
    tick();
    check("t1_released", 32'(key_held), 32'd0);
    check("t1_idle", 32'(scan_state), 32'd0);

    // T2: R3 C0 held for 20 frames
    align();
    base = nstrobe;
    press(8'h18);
    exp_q.push_back(8'h18);
    frames(20);
    check("t2_one_strobe", 32'(nstrobe), 32'(base + 1));
    check("t2_held", 32'(key_held), 32'd1);
    clear_keys();
    repeat (47) tick();
    check("t2_held_2_empty", 32'(key_held), 32'd1);
    check("t2_key_holding", 32'(cur_key), 32'h18);
    tick();
    check("t2_released", 32'(key_held), 32'd0);
    check("t2_key_kept", 32'(cur_key), 32'h18);

    // T3: bounce on R1 C1
    align();
    base = nstrobe;
    press(8'h44);
    frames(2);
    check("t3_debouncing", 32'(scan_state), 32'd1);
    clear_keys();
    frames(1);
    press(8'h44);
    frames(2);
    clear_keys();
    frames(4);
    check("t3_no_strobe", 32'(nstrobe), 32'(base));
    check("t3_held", 32'(key_held), 32'd0);
    check("t3_idle", 32'(scan_state), 32'd0);
    check("t3_key", 32'(cur_key), 32'h18);

    // T4: R0 C1 + R0 C2 together after a reset
    nRst = 1'b0;
    tick();
    tick();
    nRst = 1'b1;
    base = nstrobe;
    press(8'h84);
    press(8'h82);
    frames(10);
    check("t4_no_strobe", 32'(nstrobe), 32'(base));
    check("t4_key", 32'(cur_key), 32'h00);
    check("t4_idle", 32'(scan_state), 32'd0);
    clear_keys();
    frames(1);

    // T5: R2 C2 re-press after 3 empty frames, then after only 2
    align();
    base = nstrobe;
    press(8'h22);
    exp_q.push_back(8'h22);
    frames(4);
    clear_keys();
    frames(3);
    press(8'h22);
    exp_q.push_back(8'h22);
    frames(4);
    clear_keys();
    frames(4);
    check("t5_two_strobes", 32'(nstrobe), 32'(base + 2));
    press(8'h22);
    exp_q.push_back(8'h22);
    frames(4);
    clear_keys();
    frames(2);
    press(8'h22);
    frames(4);
    clear_keys();
    frames(4);
    check("t5_short_gap", 32'(nstrobe), 32'(base + 3));
    check("t5_idle", 32'(scan_state), 32'd0);

    // T6: reset mid-debounce with R1 C0 held
    align();
    press(8'h48);
    exp_q.push_back(8'h48);
    frames(2);
    check("t6_debouncing", 32'(scan_state), 32'd1);
    nRst = 1'b0;
    #1;
    check("t6_rst_col", 32'(col_drive), 32'h8);
    check("t6_rst_strobe", 32'(strobe), 32'd0);
    check("t6_rst_key", 32'(cur_key), 32'h00);
    check("t6_rst_held", 32'(key_held), 32'd0);
    tick();
    nRst = 1'b1;
    base = nstrobe;
    repeat (47) tick();
    check("t6_no_early", 32'(nstrobe), 32'(base));
    tick();
    check("t6_strobe", 32'(nstrobe), 32'(base + 1));
    clear_keys();
    frames(4);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
